mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12: backing-RAM word-address width (RAM holds 2^ADDR_W 16-bit words).
REQ-002 The block SHALL have parameter READ_LAT, default 2: backing-RAM read latency in cycles; legal range 1..7.
REQ-003 The block SHALL have parameter OOR_DATA, default 16'hBEEF: data returned for out-of-range reads.
REQ-004 The block SHALL have one clock and one reset: synchronous, active-high, named clr.
REQ-005 The block SHALL have port clk, input, width 1: clock; all state updates on its rising edge.
REQ-006 The block SHALL have port clr, input, width 1: synchronous active-high reset.
REQ-007 The block SHALL have port mem_read_enable, input, width 1: processor read request, level.
REQ-008 The block SHALL have port mem_write_enable, input, width 1: processor write request, level.
REQ-009 The block SHALL have port mem_write_addr, input, width 32: word address used for both reads and writes.
REQ-010 The block SHALL have port mem_write_data, input, width 16: write data.
REQ-011 The block SHALL have port mem_read_data, output, width 16: registered read data.
REQ-012 The block SHALL have port stall, output, width 1: processor hold; combinational from state and request inputs.
REQ-013 The block SHALL have port ram_addr, output, width ADDR_W: mem_write_addr[ADDR_W-1:0], passed through combinationally.
REQ-014 The block SHALL have port ram_we, output, width 1: RAM write strobe.
REQ-015 The block SHALL have port ram_wdata, output, width 16: mem_write_data, passed through.
REQ-016 The block SHALL have port ram_rdata, input, width 16: RAM read data, valid READ_LAT cycles after the address is presented.
REQ-017 The block SHALL have port err_count, output, width 8: saturating count of dropped or out-of-range requests.

Function
REQ-018 The block SHALL implement states IDLE, RD_WAIT and RD_DONE; a request SHALL be accepted only in IDLE.
REQ-019 An address SHALL be in range iff mem_write_addr[31:ADDR_W]==0.
REQ-020 In IDLE with mem_write_enable=1 and the address in range, the block SHALL drive ram_we=1 in that same cycle, leave stall=0, and remain in IDLE (zero-latency write).
REQ-021 In IDLE with mem_write_enable=1 and the address out of range, the block SHALL keep ram_we=0, drop the write, and increment err_count.
REQ-022 Write SHALL take priority: in IDLE with both enables high, the block SHALL perform the write, ignore the read, and increment err_count.
REQ-023 In IDLE with only mem_read_enable=1 and the address in range (accept cycle T), the block SHALL assert stall in T, load a latency counter with READ_LAT, and go to RD_WAIT.
REQ-024 In RD_WAIT the block SHALL hold stall=1 and decrement the counter; at the cycle T+READ_LAT it SHALL register ram_rdata into mem_read_data and go to RD_DONE.
REQ-025 In RD_DONE (cycle T+READ_LAT+1) the block SHALL set stall=0, hold mem_read_data valid, ignore the requests, and return to IDLE.
REQ-026 For an out-of-range read accepted at T, the block SHALL assert stall in T only, load OOR_DATA into mem_read_data, go directly to RD_DONE, and increment err_count.
REQ-027 ram_we SHALL be 0 in every state except IDLE.
REQ-028 mem_read_data SHALL hold its last value until the next read completes.
REQ-029 err_count SHALL saturate at 8'hFF and never wrap.
REQ-030 In IDLE with no request, the block SHALL keep stall=0.

Reset
REQ-031 When clr=1 at a clock edge, the block SHALL set: state=IDLE, counter=0, mem_read_data=16'h0000, err_count=0.
REQ-032 While clr=1, the block SHALL force ram_we=0 and stall=0 combinationally, whatever the request inputs.
REQ-033 A clr asserted during RD_WAIT SHALL abort the read with no mem_read_data update and no stall in the following cycle.

Verification
REQ-034 The bench SHALL check: clr=1 for 10 cycles with mem_read_enable=1 -> stall=0, ram_we=0, mem_read_data=0, err_count=0.
REQ-035 The bench SHALL check: write addr 0x00000010, data 0x1234 -> ram_we=1 in the same cycle, ram_addr=0x010, stall never high; then read 0x10 with READ_LAT=2 -> stall high exactly 3 cycles and mem_read_data=0x1234 in the RD_DONE cycle.
REQ-036 The bench SHALL check: read at addr 0x00010000 -> stall high 1 cycle, mem_read_data=16'hBEEF, err_count=1.
REQ-037 The bench SHALL check: both enables high at addr 5 -> the write occurs, no stall, err_count increments.
REQ-038 The bench SHALL check: clr pulsed 1 cycle after a read is accepted -> IDLE next cycle, stall=0, mem_read_data=0.
REQ-039 The bench SHALL check: 300 out-of-range writes -> err_count=8'hFF and no RAM write.

Source files
------------

// File: rtl/mem_responder.sv
// Processor-side responder for a fixed-latency backing RAM: zero-latency writes,
// stalled reads, out-of-range filtering and a saturating error counter.
module mem_responder #(
  parameter int          ADDR_W   = 12,
  parameter int          READ_LAT = 2,
  parameter logic [15:0] OOR_DATA = 16'hBEEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              mem_read_enable,
  input  logic              mem_write_enable,
  input  logic [31:0]       mem_write_addr,
  input  logic [15:0]       mem_write_data,
  output logic [15:0]       mem_read_data,
  output logic              stall,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [15:0]       ram_wdata,
  input  logic [15:0]       ram_rdata,
  output logic [7:0]        err_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_DONE = 2'd2
  } state_t;

  localparam logic [2:0] LAT = 3'(READ_LAT);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] rdata_q, rdata_d;
  logic [7:0]  err_q, err_d;
  logic        in_range_s;
  logic        err_evt_s;

  assign in_range_s    = (mem_write_addr[31:ADDR_W] == '0);
  assign ram_addr      = mem_write_addr[ADDR_W-1:0];
  assign ram_wdata     = mem_write_data;
  assign mem_read_data = rdata_q;
  assign err_count     = err_q;

  // Next-state, RAM strobe and stall decode; clr masks the strobes immediately.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_evt_s = 1'b0;
    stall     = 1'b0;
    ram_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_write_enable) begin
          // Write wins; a simultaneous read is dropped and counted as an error.
          ram_we    = in_range_s;
          err_evt_s = !in_range_s || mem_read_enable;
        end else if (mem_read_enable) begin
          stall     = 1'b1;
          err_evt_s = !in_range_s;
          if (in_range_s) begin
            state_d = RD_WAIT;
            cnt_d   = LAT;
          end else begin
            state_d = RD_DONE;
            rdata_d = OOR_DATA;
          end
        end else begin
          stall = 1'b0;
        end
      end
      RD_WAIT: begin
        stall = 1'b1;
        if (cnt_q <= 3'd1) begin
          rdata_d = ram_rdata;
          state_d = RD_DONE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RD_DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
    if (clr) begin
      stall  = 1'b0;
      ram_we = 1'b0;
    end else begin
      ram_we = ram_we;
    end
    if (err_evt_s && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end else begin
      err_d = err_q;
    end
  end

  // State, latency counter, read data and error count registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      rdata_q <= 16'h0000;
      err_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed plus randomized bench for mem_responder with a RAM model and a
// transaction-level reference for data, stall length and error count.
module tb_mem_responder;
  localparam int ADDR_W   = 12;
  localparam int READ_LAT = 2;

  logic              clk = 1'b0;
  logic              clr = 1'b0;
  logic              mem_read_enable = 1'b0;
  logic              mem_write_enable = 1'b0;
  logic [31:0]       mem_write_addr = 32'h0;
  logic [15:0]       mem_write_data = 16'h0;
  logic [15:0]       mem_read_data;
  logic              stall;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [15:0]       ram_wdata;
  logic [15:0]       ram_rdata;
  logic [7:0]        err_count;

  int n_checks = 0;
  int n_fail   = 0;

  mem_responder #(.ADDR_W(ADDR_W), .READ_LAT(READ_LAT), .OOR_DATA(16'hBEEF)) dut (
    .clk(clk), .clr(clr),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
    .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .stall(stall),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Backing RAM with READ_LAT-cycle read pipeline
  logic [15:0] ram [0:(1<<ADDR_W)-1];
  logic [15:0] pipe [0:READ_LAT-1];
  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 16'h0;
    for (int i = 0; i < READ_LAT; i++) pipe[i] = 16'h0;
  end
  always @(posedge clk) begin
    pipe[0] <= ram[ram_addr];
    for (int k = 1; k < READ_LAT; k++) pipe[k] <= pipe[k-1];
    if (ram_we) ram[ram_addr] <= ram_wdata;
  end
  assign ram_rdata = pipe[READ_LAT-1];

  // Reference state
  logic [15:0] ref_mem [int];
  int          err_exp = 0;
  logic [15:0] rd_exp  = 16'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void bump_err();
    if (err_exp < 255) err_exp++;
  endfunction

  // One processor transaction; holds the request until stall drops.
  task automatic op(input logic we, input logic re, input logic [31:0] a, input logic [15:0] d);
    logic in_rng;
    int   n;
    in_rng = (a[31:ADDR_W] == '0);
    @(posedge clk); #1;
    mem_write_enable = we; mem_read_enable = re;
    mem_write_addr = a; mem_write_data = d;
    @(negedge clk);
    if (we) begin
      chk("wr_stall", {31'd0, stall}, 32'd0);
      chk("wr_we", {31'd0, ram_we}, {31'd0, in_rng});
      if (in_rng) begin
        chk("wr_addr", {20'd0, ram_addr}, {20'd0, a[ADDR_W-1:0]});
        chk("wr_data", {16'd0, ram_wdata}, {16'd0, d});
        ref_mem[int'(a)] = d;
      end
      if (!in_rng || re) bump_err();
    end else if (re) begin
      n = 0;
      while (stall && n < 20) begin
        n++;
        @(negedge clk);
      end
      chk("rd_stall_len", n, in_rng ? READ_LAT + 1 : 1);
      if (in_rng) rd_exp = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'h0;
      else begin
        rd_exp = 16'hBEEF;
        bump_err();
      end
      chk("rd_data", {16'd0, mem_read_data}, {16'd0, rd_exp});
    end else begin
      chk("idle_stall", {31'd0, stall}, 32'd0);
      chk("idle_we", {31'd0, ram_we}, 32'd0);
    end
    @(posedge clk); #1;
    mem_write_enable = 1'b0; mem_read_enable = 1'b0;
    @(negedge clk);
    chk("err_count", {24'd0, err_count}, err_exp);
    chk("hold_data", {16'd0, mem_read_data}, {16'd0, rd_exp});
    chk("post_stall", {31'd0, stall}, 32'd0);
  endtask

  task automatic do_clr(input int cycles, input logic re);
    @(posedge clk); #1;
    clr = 1'b1; mem_read_enable = re; mem_write_enable = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk("clr_stall", {31'd0, stall}, 32'd0);
      chk("clr_we", {31'd0, ram_we}, 32'd0);
      if (i > 0) begin
        chk("clr_rdata", {16'd0, mem_read_data}, 32'd0);
        chk("clr_err", {24'd0, err_count}, 32'd0);
      end
      @(posedge clk); #1;
    end
    clr = 1'b0; mem_read_enable = 1'b0;
    err_exp = 0; rd_exp = 16'h0;
  endtask

  initial begin
    logic [31:0] a;
    int sel;
    // Reset held with a pending read
    do_clr(10, 1'b1);
    @(negedge clk);
    chk("rst_rdata", {16'd0, mem_read_data}, 32'd0);
    chk("rst_err", {24'd0, err_count}, 32'd0);

    // Write then read back
    op(1'b1, 1'b0, 32'h0000_0010, 16'h1234);
    op(1'b0, 1'b1, 32'h0000_0010, 16'h0000);
    // Out-of-range read
    op(1'b0, 1'b1, 32'h0001_0000, 16'h0000);
    chk("oor_err1", {24'd0, err_count}, 32'd1);
    // Both enables: write wins and counts an error
    op(1'b1, 1'b1, 32'h0000_0005, 16'hA5A5);
    chk("both_err2", {24'd0, err_count}, 32'd2);
    op(1'b0, 1'b1, 32'h0000_0005, 16'h0000);
    chk("both_data", {16'd0, mem_read_data}, 32'h0000A5A5);

    // clr one cycle after a read is accepted
    @(posedge clk); #1;
    mem_read_enable = 1'b1; mem_write_addr = 32'h0000_0010;
    @(negedge clk);
    chk("abort_accept", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    clr = 1'b1; mem_read_enable = 1'b0;
    @(negedge clk);
    chk("abort_clr_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    clr = 1'b0;
    err_exp = 0; rd_exp = 16'h0;
    @(negedge clk);
    chk("abort_stall", {31'd0, stall}, 32'd0);
    chk("abort_rdata", {16'd0, mem_read_data}, 32'd0);
    chk("abort_err", {24'd0, err_count}, 32'd0);
    op(1'b0, 1'b1, 32'h0000_0010, 16'h0000);

    // Error counter saturation
    for (int i = 0; i < 300; i++) op(1'b1, 1'b0, 32'h0000_1000 | (i << 13), 16'(i));
    chk("sat_err", {24'd0, err_count}, 32'h0000_00FF);
    op(1'b0, 1'b1, 32'h0000_0010, 16'h0000);
    chk("sat_keep_data", {16'd0, mem_read_data}, 32'h0000_1234);

    // Randomized traffic
    do_clr(2, 1'b0);
    for (int i = 0; i < 250; i++) begin
      sel = int'($urandom_range(0, 3));
      a = (sel == 0) ? ($urandom() | 32'h0000_1000) : 32'($urandom_range(0, 63));
      op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 16'($urandom()));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
